bram_port_arbiter: RTL and testbench

// Shares one port of the dual-port BRAM (Bramtop-style, 10-bit address, 8-bit data,
// 1-cycle synchronous read) between two requesters (m0, m1). Round-robin arbitration

---
 rtl/bram_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_bram_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of one synchronous BRAM port.
// Round-robin grant with a bounded ownership lock for bursts.
module bram_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state;
  logic             prio;
  logic [CNT_W-1:0] lock_cnt;
  logic             rv0_q;
  logic             rv1_q;
  logic             g0;
  logic             g1;

  // grant decode: owner-only while locked, else round-robin on prio
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          g0 = m0_req & (~m1_req | ~prio);
          g1 = m1_req & (~m0_req | prio);
        end
        OWN0: g0 = m0_req;
        OWN1: g1 = m1_req;
        default: ;
      endcase
    end
  end

  assign m0_gnt = g0;
  assign m1_gnt = g1;

  // BRAM port mux from the granted master, idle value zero
  always_comb begin
    bram_en   = g0 | g1;
    bram_we   = (g0 & m0_we) | (g1 & m1_we);
    bram_addr = '0;
    bram_din  = '0;
    if (g0) begin
      bram_addr = m0_addr;
      bram_din  = m0_wdata;
    end else if (g1) begin
      bram_addr = m1_addr;
      bram_din  = m1_wdata;
    end
  end

  // ownership FSM with priority pointer and lock beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      lock_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (g0) begin
            if (m0_lock) begin
              state    <= OWN0;
              lock_cnt <= ONE;
            end else begin
              prio <= 1'b1;
            end
          end else if (g1) begin
            if (m1_lock) begin
              state    <= OWN1;
              lock_cnt <= ONE;
            end else begin
              prio <= 1'b0;
            end
          end
        end
        OWN0: begin
          if (g0 && m0_lock && lock_cnt < MAX_CNT) begin
            lock_cnt <= lock_cnt + ONE;
          end else begin
            state    <= IDLE;
            prio     <= 1'b1;
            lock_cnt <= '0;
          end
        end
        OWN1: begin
          if (g1 && m1_lock && lock_cnt < MAX_CNT) begin
            lock_cnt <= lock_cnt + ONE;
          end else begin
            state    <= IDLE;
            prio     <= 1'b0;
            lock_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      endcase
    end
  end

  // read-return tags, one cycle behind the accepted read
  always_ff @(posedge clk) begin
    if (rst) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      rv0_q <= g0 & ~m0_we;
      rv1_q <= g1 & ~m1_we;
    end
  end

  // a reset cycle also suppresses a return already in flight
  assign m0_rvalid = rv0_q & ~rst;
  assign m1_rvalid = rv1_q & ~rst;
  assign m0_rdata  = bram_dout;
  assign m1_rdata  = bram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a behavioural
// arbitration model and a BRAM model.
module tb_bram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int ML = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req[2];
  logic          lock[2];
  logic          we[2];
  logic [AW-1:0] addr[2];
  logic [DW-1:0] wdata[2];

  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;

  bram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_lock(lock[0]), .m0_we(we[0]),
    .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_lock(lock[1]), .m1_we(we[1]),
    .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  logic [DW-1:0] mem[1024];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else bram_dout <= mem[bram_addr];
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [DW-1:0] shadow[1024];
  int owner = -1;
  int prio  = 0;
  int beats = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               name, cycle, act, exp);
    end
  endtask

  function automatic int pick();
    if (rst) return -1;
    if (owner >= 0) return req[owner] ? owner : -1;
    if (req[0] && req[1]) return prio;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic step();
    int   g;
    exp_t e;
    @(negedge clk);
    g = pick();
    chk("m0_gnt", m0_gnt, (g == 0) ? 1 : 0);
    chk("m1_gnt", m1_gnt, (g == 1) ? 1 : 0);
    chk("bram_en", bram_en, (g >= 0) ? 1 : 0);
    chk("bram_we", bram_we, (g >= 0) ? we[g] : 0);
    chk("bram_addr", bram_addr, (g >= 0) ? addr[g] : 0);
    chk("bram_din", bram_din, (g >= 0) ? wdata[g] : 0);
    if (g >= 0) begin
      if (we[g]) begin
        shadow[addr[g]] = wdata[g];
      end else begin
        e.data = shadow[addr[g]];
        e.due  = cycle + 1;
        if (g == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
    if (rst) begin
      owner = -1; prio = 0; beats = 0;
    end else if (owner >= 0) begin
      if (g >= 0 && lock[owner] && beats < ML) begin
        beats++;
      end else begin
        prio = 1 - owner; owner = -1; beats = 0;
      end
    end else if (g >= 0) begin
      if (lock[g]) begin
        owner = g; beats = 1;
      end else begin
        prio = 1 - g;
      end
    end
    @(posedge clk);
    cycle++;
    #1;
  endtask

  task automatic drive(input int m, input bit r, input bit l,
                       input bit w, input int a, input int d);
    req[m]   = r;
    lock[m]  = l;
    we[m]    = w;
    addr[m]  = AW'(a);
    wdata[m] = DW'(d);
  endtask

  // return monitor: rvalid/rdata against scoreboard queues
  initial begin
    exp_t e;
    bit   ev;
    forever begin
      @(negedge clk);
      ev = q0.size() > 0 && q0[0].due == cycle && !rst;
      chk("m0_rvalid", m0_rvalid, ev);
      if (q0.size() > 0 && q0[0].due <= cycle) begin
        e = q0.pop_front();
        if (ev && m0_rvalid) chk("m0_rdata", m0_rdata, e.data);
      end
      ev = q1.size() > 0 && q1[0].due == cycle && !rst;
      chk("m1_rvalid", m1_rvalid, ev);
      if (q1.size() > 0 && q1[0].due <= cycle) begin
        e = q1.pop_front();
        if (ev && m1_rvalid) chk("m1_rdata", m1_rdata, e.data);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = '0;
    drive(0, 1, 0, 0, 'h010, 0);
    drive(1, 1, 0, 0, 'h025, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 'h010, 'hAA);
    step();
    drive(0, 1, 0, 1, 'h025, 'hBB);
    step();
    drive(0, 1, 0, 0, 'h010, 0);
    step();
    drive(0, 1, 0, 0, 'h025, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 1, 0, 0, 'h010, 0);
    drive(1, 1, 0, 0, 'h025, 0);
    for (int i = 0; i < 8; i++) step();
    drive(0, 1, 0, 0, 'h025, 0);
    drive(1, 1, 1, 0, 'h010, 0);
    for (int i = 0; i < 40; i++) step();
    drive(1, 1, 0, 0, 'h025, 0);
    drive(0, 1, 1, 0, 'h010, 0);
    for (int i = 0; i < 3; i++) step();
    drive(0, 0, 1, 0, 'h010, 0);
    step();
    drive(0, 1, 0, 0, 'h010, 0);
    for (int i = 0; i < 3; i++) step();
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 'h025, 0);
    step();
    drive(1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 1, 'h100 + i, $urandom_range(0, 255));
      step();
    end
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        drive(m, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 2) == 0, 'h100 + $urandom_range(0, 7),
              $urandom_range(0, 255));
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
